count_stream_checker: RTL and testbench

- Receive end of the counter output stream. Accepts 8-bit samples strobed on the shared Tiny Tapeout pin set and checks that each sample equals the previous one plus STEP, modulo 2^WIDTH.
- Locks onto the sequence, then counts good and bad samples.
- Reports status and counters through the standard ui/uo/uio pin set, so it can sit downstream of the counter on the same harness.

---
 rtl/count_stream_checker.sv | 121 ++++++++++++
 tb/tb_count_stream_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_stream_checker.sv
// Receive-side checker for an incrementing sample stream: locks onto the
// sequence, then counts matching and mismatching samples, readable via uo_out.
module count_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [7:0]       uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] exp_q, last_q;
  logic [RW-1:0]    run_q;
  logic [MW-1:0]    miss_q;
  logic [7:0]       err_q;
  logic [15:0]      good_q;
  logic             sticky_q, pulse_q;

  logic             clear_d, accept_d, match_d;
  logic [WIDTH-1:0] exp_d;
  logic [RW-1:0]    run_d;
  logic [MW-1:0]    miss_d;
  logic             unused_bits;

  // Clear wins over a simultaneous valid; both are ignored while ena is low.
  assign clear_d  = ena & uio_in[3];
  assign accept_d = ena & uio_in[0] & ~uio_in[3];
  assign match_d  = (ui_in == exp_q);
  assign exp_d    = ui_in + WIDTH'(STEP);
  assign run_d    = run_q + 1'b1;
  assign miss_d   = miss_q + 1'b1;
  assign unused_bits = ^uio_in[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      exp_q    <= '0;
      last_q   <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      good_q   <= '0;
      sticky_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (clear_d) begin
        state_q  <= SEARCH;
        run_q    <= '0;
        miss_q   <= '0;
        err_q    <= '0;
        good_q   <= '0;
        sticky_q <= 1'b0;
      end else if (accept_d) begin
        last_q <= ui_in;
        exp_q  <= exp_d;
        unique case (state_q)
          SEARCH: begin
            run_q   <= RW'(1);
            state_q <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match_d) begin
              run_q <= run_d;
              if (run_d == RW'(LOCK_COUNT)) begin
                state_q <= LOCKED;
                miss_q  <= '0;
              end
            end else begin
              run_q <= RW'(1);
            end
          end
          LOCKED: begin
            if (match_d) begin
              if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
              miss_q  <= '0;
              pulse_q <= 1'b1;
            end else begin
              if (err_q != 8'hFF) err_q <= err_q + 8'd1;
              sticky_q <= 1'b1;
              miss_q   <= miss_d;
              if (miss_d == MW'(LOSS_COUNT)) begin
                state_q <= SEARCH;
                run_q   <= '0;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  always_comb begin
    uo_out = 8'h00;
    unique case (uio_in[2:1])
      2'd0: uo_out = 8'(last_q);
      2'd1: uo_out = err_q;
      2'd2: uo_out = good_q[7:0];
      2'd3: uo_out = good_q[15:8];
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = {pulse_q, state_q == ACQUIRE, sticky_q, state_q == LOCKED, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_count_stream_checker.sv
// Randomized bench for count_stream_checker: a behavioural model of the stream
// rules is compared against uo_out/uio_out every cycle, plus literal checkpoints.
module tb_count_stream_checker;
  localparam int STEP = 1;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  count_stream_checker #(.WIDTH(8), .STEP(STEP), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  // Model: 0=SEARCH 1=ACQUIRE 2=LOCKED
  int m_state, m_exp, m_last, m_run, m_miss, m_err, m_good, m_sticky, m_pulse;
  int last_fed;

  task automatic check(input string name, input int act, input int want);
    n_tot++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_last = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_good = 0; m_sticky = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int hit;
    int pulse;
    pulse = 0;
    if (ena && uio_in[3]) begin
      m_state = 0; m_err = 0; m_good = 0; m_sticky = 0; m_run = 0; m_miss = 0;
    end else if (ena && uio_in[0]) begin
      hit    = (int'(ui_in) == m_exp);
      m_last = int'(ui_in);
      m_exp  = (int'(ui_in) + STEP) % 256;
      if (m_state == 0) begin
        m_run = 1; m_state = 1;
      end else if (m_state == 1) begin
        m_run = hit ? m_run + 1 : 1;
        if (m_run == LOCK) begin m_state = 2; m_miss = 0; end
      end else begin
        if (hit) begin
          m_good = (m_good < 65535) ? m_good + 1 : 65535;
          m_miss = 0;
          pulse  = 1;
        end else begin
          m_err    = (m_err < 255) ? m_err + 1 : 255;
          m_sticky = 1;
          m_miss++;
          if (m_miss == LOSS) begin m_state = 0; m_run = 0; end
        end
      end
    end
    m_pulse = pulse;
  endtask

  function automatic int exp_uo(input logic [1:0] sel);
    case (sel)
      2'd0: return m_last;
      2'd1: return m_err;
      2'd2: return m_good % 256;
      default: return m_good / 256;
    endcase
  endfunction

  function automatic int exp_uio();
    return m_pulse * 128 + (m_state == 1 ? 64 : 0) + m_sticky * 32 + (m_state == 2 ? 16 : 0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("uo_out", int'(uo_out), exp_uo(uio_in[2:1]));
      check("uio_out", int'(uio_out), exp_uio());
      check("uio_oe", int'(uio_oe), 8'hF0);
    end
  end

  task automatic step(input logic en, input logic v, input logic clr,
                      input logic [1:0] sel, input logic [7:0] d);
    ena = en; ui_in = d; uio_in = {4'b0000, clr, sel, v};
    if (en && v && !clr) last_fed = int'(d);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    step(1'b1, 1'b1, 1'b0, 2'd0, d);
  endtask

  // Idle cycle-free readout: changes the select only, no clock edge.
  task automatic peek(input logic [1:0] sel, input string name, input int want);
    uio_in = {4'b0000, 1'b0, sel, 1'b0};
    #1;
    check(name, int'(uo_out), want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    model_reset();
    last_fed = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_uio_out", int'(uio_out), 0);
    check("reset_uo_out", int'(uo_out), 0);
    check("reset_uio_oe", int'(uio_oe), 8'hF0);
    rst = 1'b0;
    chk_en = 1'b1;

    feed(8'd10);
    check("acq_after_10", int'(uio_out), 8'h40);
    feed(8'd11); feed(8'd12); feed(8'd13);
    check("locked_after_13", int'(uio_out), 8'h10);
    peek(2'd1, "err_after_lock", 0);
    peek(2'd2, "good_after_lock", 0);

    for (int i = 14; i <= 20; i++) begin
      feed(8'(i));
      check("pulse_14_20", int'(uio_out[7]), 1);
    end
    peek(2'd2, "good_7", 7);
    peek(2'd0, "last_20", 20);

    feed(8'd50);
    peek(2'd1, "err_1", 1);
    check("sticky_locked", int'(uio_out[5:4]), 3);
    feed(8'd51);
    peek(2'd2, "good_resync", 8);

    feed(8'd5); feed(8'd99); feed(8'd7);
    peek(2'd1, "err_4", 4);
    check("search_after_loss", int'(uio_out), 8'h20);

    for (int i = 249; i <= 252; i++) feed(8'(i));
    feed(8'd253); feed(8'd254); feed(8'd255); feed(8'd0); feed(8'd1);
    peek(2'd2, "good_wrap", 13);
    peek(2'd1, "err_wrap", 4);

    for (int i = 0; i < 260; i++) begin
      feed(8'(m_exp ^ 8'h80));
      feed(8'(m_exp));
    end
    peek(2'd1, "err_sat", 255);
    check("locked_sat", int'(uio_out[4]), 1);

    d = 8'(last_fed);
    step(1'b1, 1'b1, 1'b1, 2'd0, 8'hAA);
    check("clear_uio_out", int'(uio_out), 0);
    peek(2'd0, "clear_keeps_last", int'(d));
    peek(2'd1, "clear_err", 0);
    peek(2'd3, "clear_good_hi", 0);

    for (int i = 0; i < 4; i++) feed(8'(m_exp));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 8'(i * 37));
    check("ena_low_hold", int'(uio_out[4]), 1);
    peek(2'd0, "ena_low_last", 8'(last_fed));

    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 9) < 8) ? 8'(m_exp) : 8'($urandom_range(0, 255));
      step($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)), d);
    end

    for (int i = 0; i < 4; i++) feed(8'(m_exp));
    check("locked_before_rst", int'(uio_out[4]), 1);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_uio_out", int'(uio_out), 0);
    check("async_rst_uo_out", int'(uo_out), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) feed(8'(100 + i));
    peek(2'd2, "good_after_rst", 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
